// File: rtl/encoded_byte_serializer.sv
// encoded_byte_serializer
//   Buffers encoded bytes from the convolutional encoder in a small FIFO and
//   sends each one as an 11-bit frame on a single line:
//   start(0), 8 data bits MSB first, even parity, stop(1).
//   Every bit is held for BIT_CYCLES clocks; frames go out back-to-back while
//   the FIFO holds data.
//
// Parameters
//   FIFO_DEPTH : FIFO entries (power of 2, >= 2)
//   BIT_CYCLES : clocks per serial bit (>= 1)
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   encodedOutput : byte from the encoder stage
//   encodedValid  : encodedOutput holds a byte to transfer
//   encodedReady  : a byte can be accepted this cycle
//   txData        : serial line, idles high (registered)
//   txBusy        : a frame is in progress (registered)
//   fifoCount     : bytes currently buffered (registered)
module encoded_byte_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    encodedOutput,
    input  logic                          encodedValid,
    output logic                          encodedReady,
    output logic                          txData,
    output logic                          txBusy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_parity;
    logic             w_parity_nxt;
    logic [CYC_W-1:0] r_cycle;
    logic [CYC_W-1:0] w_cycle_nxt;
    logic [2:0]       r_bitcnt;
    logic [2:0]       w_bitcnt_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             r_busy;
    logic             w_push;
    logic             w_pop;
    logic             w_have;
    logic             w_bit_end;
    logic [7:0]       w_head;

    assign encodedReady = (r_count < FULL);
    assign txData       = r_tx;
    assign txBusy       = r_busy;
    assign fifoCount    = r_count;

    assign w_push    = encodedValid && encodedReady;
    assign w_have    = (r_count != '0);
    assign w_head    = r_mem[r_rptr];
    assign w_bit_end = (r_cycle == CYC_LAST);

    // Next-state logic. The line value is derived from the *next* state and
    // shift contents so that txData can be registered yet still show the
    // start bit on the same edge that pops the byte.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_cycle_nxt  = r_cycle;
        w_bitcnt_nxt = r_bitcnt;
        w_pop        = 1'b0;

        if (r_state != S_IDLE) begin
            w_cycle_nxt = w_bit_end ? '0 : r_cycle + 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_have) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_parity_nxt = ^w_head;
                    w_cycle_nxt  = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_have) begin
                        // chain straight into the next frame, no idle bit
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_parity_nxt = ^w_head;
                        w_state_nxt  = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        unique case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[7];
            S_PARITY: w_tx_nxt = w_parity_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_cycle  <= '0;
            r_bitcnt <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_cycle  <= w_cycle_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= encodedOutput;
        end
    end

endmodule

// File: tb/tb_encoded_byte_serializer.sv
// Self-checking bench for encoded_byte_serializer.
// Two instances: BIT_CYCLES=4/FIFO_DEPTH=4 and BIT_CYCLES=1/FIFO_DEPTH=2,
// exercised one at a time through a shared stimulus/observation mux.
`timescale 1ns/1ps
module tb_encoded_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tb_data;
    logic       tb_valid;
    logic       sel;

    logic       v0, v1, rdy0, rdy1, tx0, tx1, busy0, busy1;
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    logic       s_tx, s_busy, s_rdy;
    int         s_cnt;

    always #5 clk = ~clk;

    assign v0     = tb_valid & ~sel;
    assign v1     = tb_valid & sel;
    assign s_tx   = sel ? tx1 : tx0;
    assign s_busy = sel ? busy1 : busy0;
    assign s_rdy  = sel ? rdy1 : rdy0;
    assign s_cnt  = sel ? int'(cnt1) : int'(cnt0);

    encoded_byte_serializer #(.FIFO_DEPTH(4), .BIT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .encodedOutput(tb_data), .encodedValid(v0),
        .encodedReady(rdy0), .txData(tx0), .txBusy(busy0), .fifoCount(cnt0)
    );

    encoded_byte_serializer #(.FIFO_DEPTH(2), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .encodedOutput(tb_data), .encodedValid(v1),
        .encodedReady(rdy1), .txData(tx1), .txBusy(busy1), .fifoCount(cnt1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is an 11-bit sequence; the model tracks which byte is on the
    // line and how many clocks into the frame we are.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    int         m_pos;
    bit         m_active;
    bit         m_acc;
    int         m_bc = 4;
    int         m_fd = 4;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[8-k];
        if (k == 9) return ^b;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_acc    = 1'b0;
        end else begin
            int n0;
            n0    = mq.size();
            m_acc = tb_valid && (n0 < m_fd);
            if (m_active) begin
                m_pos++;
                if (m_pos == 11 * m_bc) begin
                    if (n0 > 0) begin
                        m_cur = mq.pop_front();
                        m_pos = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (n0 > 0) begin
                m_cur    = mq.pop_front();
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (m_acc) mq.push_back(tb_data);
        end
    end

    // ---------------- cycle checker ----------------
    bit chk_en     = 1'b0;
    int busy_clk   = 0;
    int busy_falls = 0;
    bit seen_full  = 1'b0;
    bit prev_busy  = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            int ex;
            ex = m_active ? int'(frame_bit(m_cur, m_pos / m_bc)) : 1;
            check("line", int'(s_tx), ex);
            check("busy", int'(s_busy), int'(m_active));
            check("count", s_cnt, mq.size());
            check("ready", int'(s_rdy), (mq.size() < m_fd) ? 1 : 0);
            if (s_busy) busy_clk++;
            if (prev_busy && !s_busy) busy_falls++;
            if (mq.size() == m_fd && !s_rdy) seen_full = 1'b1;
            prev_busy = s_busy;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst      = 1'b1;
        tb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        busy_clk   = 0;
        busy_falls = 0;
        seen_full  = 1'b0;
    endtask

    // Present a byte and hold it until accepted. Called and returns at
    // posedge+1ns.
    task automatic send(input logic [7:0] b, input int max_wait);
        int w;
        tb_data  = b;
        tb_valid = 1'b1;
        w        = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!m_acc && w < max_wait);
        if (!m_acc) check("send_timeout", 0, 1);
        tb_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((m_active || mq.size() != 0 || s_busy) && w < max_cyc);
        if (m_active || mq.size() != 0 || s_busy) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // [10] = start bit ... [0] = stop bit
    } vec_t;

    vec_t vecs[6];
    logic smp[44];
    int   nbusy;

    initial begin
        vecs[0] = '{8'hA5, 11'b0_10100101_0_1};
        vecs[1] = '{8'h07, 11'b0_00000111_1_1};
        vecs[2] = '{8'h00, 11'b0_00000000_0_1};
        vecs[3] = '{8'hFF, 11'b0_11111111_0_1};
        vecs[4] = '{8'h01, 11'b0_00000001_1_1};
        vecs[5] = '{8'h80, 11'b0_10000000_1_1};

        sel      = 1'b0;
        tb_data  = '0;
        tb_valid = 1'b0;
        rst      = 1'b1;
        #2;
        do_reset();

        check("rst_tx", int'(s_tx), 1);
        check("rst_busy", int'(s_busy), 0);
        check("rst_count", s_cnt, 0);
        check("rst_ready", int'(s_rdy), 1);
        chk_en = 1'b1;

        // single frames, table driven
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].data, 5);
            @(posedge clk);
            nbusy = 0;
            for (int i = 0; i < 44; i++) begin
                @(negedge clk);
                smp[i] = s_tx;
                if (s_busy) nbusy++;
                @(posedge clk);
            end
            @(negedge clk);
            check($sformatf("v%0d_idle_tx", v), int'(s_tx), 1);
            check($sformatf("v%0d_idle_busy", v), int'(s_busy), 0);
            check($sformatf("v%0d_busy_clks", v), nbusy, 44);
            for (int k = 0; k < 11; k++) begin
                logic [10:0] fr;
                fr = vecs[v].frame;
                check($sformatf("v%0d_bit%0d", v, k), int'(smp[k*4 + 2]), int'(fr[10-k]));
            end
            @(posedge clk);
            #1;
        end

        // back-to-back frames
        do_reset();
        send(8'h3C, 5);
        send(8'hFF, 5);
        wait_idle(300);
        check("b2b_busy_clks", busy_clk, 88);
        check("b2b_busy_falls", busy_falls, 1);

        // valid held with 6 bytes while the first frame transmits
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), 100);
        wait_idle(400);
        check("flood_busy_clks", busy_clk, 264);
        check("flood_busy_falls", busy_falls, 1);
        check("flood_seen_full", int'(seen_full), 1);

        // reset in the middle of the data bits of 0x5A with 2 bytes queued
        do_reset();
        send(8'h5A, 5);
        send(8'h11, 5);
        send(8'h22, 5);
        repeat (12) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(s_busy), 1);
        check("pre_rst_count", s_cnt, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", int'(s_tx), 1);
        check("mid_rst_busy", int'(s_busy), 0);
        check("mid_rst_count", s_cnt, 0);
        check("mid_rst_ready", int'(s_rdy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        busy_clk = 0;
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_no_frames", busy_clk, 0);

        // randomized stream on the BIT_CYCLES=4 instance
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom_range(0, 255)), 100);
            repeat ($urandom_range(0, 30)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(600);
        check("rand4_busy_clks", busy_clk, 440);

        // BIT_CYCLES=1, FIFO_DEPTH=2 instance, 8 bytes with pointer wrap
        sel  = 1'b1;
        m_bc = 1;
        m_fd = 2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom_range(0, 255)), 40);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(200);
        check("bc1_busy_clks", busy_clk, 88);
        check("bc1_seen_full", int'(seen_full), 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
